// File: rtl/const_ctrl_pipe.sv
// DOF-to-EX helper: immediate extension unit plus the loadable control-field
// pipeline flops, with the en->en_if and mc->mc_pre delay registers.
module const_ctrl_pipe #(
  parameter int unsigned IMM_W  = 15,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [IMM_W-1:0]  imm,
  input  logic              cs,
  output logic [DATA_W-1:0] constant,
  input  logic              en,
  output logic              en_if,
  input  logic [1:0]        mc,
  output logic [1:0]        mc_pre,
  input  logic              ps_d,
  input  logic              rw_d,
  input  logic              mw_d,
  input  logic              ma_d,
  input  logic              mb_d,
  input  logic [1:0]        md_d,
  input  logic [1:0]        bs_d,
  output logic              ps_q,
  output logic              rw_q,
  output logic              mw_q,
  output logic              ma_q,
  output logic              mb_q,
  output logic [1:0]        md_q,
  output logic [1:0]        bs_q
);

  // Fill the whole word with the extension bit first, then overlay the
  // immediate; this stays legal when DATA_W equals IMM_W.
  always_comb begin
    constant = cs ? {DATA_W{imm[IMM_W-1]}} : '0;
    constant[IMM_W-1:0] = imm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_if  <= 1'b0;
      mc_pre <= '0;
      ps_q   <= 1'b0;
      rw_q   <= 1'b0;
      mw_q   <= 1'b0;
      ma_q   <= 1'b0;
      mb_q   <= 1'b0;
      md_q   <= '0;
      bs_q   <= '0;
    end else if (load) begin
      en_if  <= en;
      mc_pre <= mc;
      // A flushed slot becomes a NOP in EX; the delay flops keep tracking.
      if (flush) begin
        ps_q <= 1'b0;
        rw_q <= 1'b0;
        mw_q <= 1'b0;
        ma_q <= 1'b0;
        mb_q <= 1'b0;
        md_q <= '0;
        bs_q <= '0;
      end else begin
        ps_q <= ps_d;
        rw_q <= rw_d;
        mw_q <= mw_d;
        ma_q <= ma_d;
        mb_q <= mb_d;
        md_q <= md_d;
        bs_q <= bs_d;
      end
    end
  end

endmodule

// File: tb/tb_const_ctrl_pipe.sv
// Directed bench for const_ctrl_pipe: per-cycle vector table plus hand-written
// sequences for mid-cycle reset and combinational constant behaviour.
module tb_const_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n, load, flush, cs, en;
  logic [14:0] imm;
  logic [1:0]  mc;
  logic [8:0]  ctrl_d;   // {ps,rw,mw,ma,mb,md[1:0],bs[1:0]}
  logic [31:0] constant;
  logic        en_if;
  logic [1:0]  mc_pre;
  logic        ps_q, rw_q, mw_q, ma_q, mb_q;
  logic [1:0]  md_q, bs_q;
  logic [8:0]  ctrl_q;

  assign ctrl_q = {ps_q, rw_q, mw_q, ma_q, mb_q, md_q, bs_q};

  always #5 clk = ~clk;

  const_ctrl_pipe #(.IMM_W(15), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .flush(flush),
    .imm(imm), .cs(cs), .constant(constant),
    .en(en), .en_if(en_if), .mc(mc), .mc_pre(mc_pre),
    .ps_d(ctrl_d[8]), .rw_d(ctrl_d[7]), .mw_d(ctrl_d[6]), .ma_d(ctrl_d[5]),
    .mb_d(ctrl_d[4]), .md_d(ctrl_d[3:2]), .bs_d(ctrl_d[1:0]),
    .ps_q(ps_q), .rw_q(rw_q), .mw_q(mw_q), .ma_q(ma_q), .mb_q(mb_q),
    .md_q(md_q), .bs_q(bs_q)
  );

  typedef struct {
    logic        rst_n, load, flush, en;
    logic [1:0]  mc;
    logic [8:0]  ctrl;
    logic [14:0] imm;
    logic        cs;
    logic        x_en_if;
    logic [1:0]  x_mc_pre;
    logic [8:0]  x_ctrl;
    logic [31:0] x_const;
  } vec_t;

  vec_t vecs[14];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //          rst ld fl en  mc     ctrl     imm       cs  en_if mc_pre  ctrl     constant
    vecs[0]  = '{0, 1, 0, 1, 2'b11, 9'h1FF, 15'h4000, 1, 0, 2'b00, 9'h000, 32'hFFFFC000};
    vecs[1]  = '{1, 1, 0, 1, 2'b11, 9'h1FF, 15'h4000, 0, 1, 2'b11, 9'h1FF, 32'h00004000};
    vecs[2]  = '{1, 1, 0, 1, 2'b00, 9'h0AA, 15'h3FFF, 1, 1, 2'b00, 9'h0AA, 32'h00003FFF};
    vecs[3]  = '{1, 1, 0, 0, 2'b01, 9'h155, 15'h0000, 1, 0, 2'b01, 9'h155, 32'h00000000};
    vecs[4]  = '{1, 1, 0, 1, 2'b10, 9'h0F0, 15'h7FFF, 1, 1, 2'b10, 9'h0F0, 32'hFFFFFFFF};
    vecs[5]  = '{1, 1, 0, 1, 2'b11, 9'h00F, 15'h7FFF, 0, 1, 2'b11, 9'h00F, 32'h00007FFF};
    // hold for three cycles while inputs move; the flush in the last one is lost
    vecs[6]  = '{1, 0, 0, 0, 2'b00, 9'h1FF, 15'h5555, 1, 1, 2'b11, 9'h00F, 32'hFFFFD555};
    vecs[7]  = '{1, 0, 0, 0, 2'b01, 9'h123, 15'h1555, 1, 1, 2'b11, 9'h00F, 32'h00001555};
    vecs[8]  = '{1, 0, 1, 1, 2'b10, 9'h000, 15'h0001, 0, 1, 2'b11, 9'h00F, 32'h00000001};
    vecs[9]  = '{1, 1, 0, 0, 2'b00, 9'h0AB, 15'h4001, 1, 0, 2'b00, 9'h0AB, 32'hFFFFC001};
    // flush: rw=1, md=01, bs=10 (all other bits 1) -> bubble, mc_pre still tracks
    vecs[10] = '{1, 1, 1, 1, 2'b10, 9'h1F6, 15'h0080, 1, 1, 2'b10, 9'h000, 32'h00000080};
    vecs[11] = '{1, 1, 0, 0, 2'b01, 9'h1F6, 15'h0080, 0, 0, 2'b01, 9'h1F6, 32'h00000080};
    vecs[12] = '{1, 1, 0, 1, 2'b10, 9'h1F6, 15'h0080, 0, 1, 2'b10, 9'h1F6, 32'h00000080};
    vecs[13] = '{1, 1, 1, 0, 2'b11, 9'h1FF, 15'h2AAA, 1, 0, 2'b11, 9'h000, 32'h00002AAA};

    rst_n = 1'b0; load = 1'b0; flush = 1'b0; en = 1'b0; mc = '0;
    ctrl_d = '0; imm = '0; cs = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; load = vecs[i].load; flush = vecs[i].flush;
      en = vecs[i].en; mc = vecs[i].mc; ctrl_d = vecs[i].ctrl;
      imm = vecs[i].imm; cs = vecs[i].cs;
      #1;
      check($sformatf("v%0d constant", i), constant, vecs[i].x_const);
      @(posedge clk); #1;
      check($sformatf("v%0d en_if", i), {31'd0, en_if}, {31'd0, vecs[i].x_en_if});
      check($sformatf("v%0d mc_pre", i), {30'd0, mc_pre}, {30'd0, vecs[i].x_mc_pre});
      check($sformatf("v%0d ctrl_q", i), {23'd0, ctrl_q}, {23'd0, vecs[i].x_ctrl});
    end

    // Load a known non-zero state, then drop rst_n between edges.
    @(negedge clk);
    rst_n = 1'b1; load = 1'b1; flush = 1'b0; en = 1'b1; mc = 2'b10; ctrl_d = 9'h1C5;
    @(posedge clk); #1;
    check("pre-reset ctrl_q", {23'd0, ctrl_q}, 32'h1C5);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midcycle ctrl_q", {23'd0, ctrl_q}, 32'h1C5);
    check("midcycle mc_pre", {30'd0, mc_pre}, 32'h2);
    check("midcycle en_if", {31'd0, en_if}, 32'h1);
    @(posedge clk); #1;
    check("sync reset ctrl_q", {23'd0, ctrl_q}, 32'h0);
    check("sync reset mc_pre", {30'd0, mc_pre}, 32'h0);
    check("sync reset en_if", {31'd0, en_if}, 32'h0);
    // Release mid-cycle: nothing moves until the first edge with rst_n=1.
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("release hold ctrl_q", {23'd0, ctrl_q}, 32'h0);
    @(posedge clk); #1;
    check("release ctrl_q", {23'd0, ctrl_q}, 32'h1C5);
    check("release mc_pre", {30'd0, mc_pre}, 32'h2);

    // Constant follows imm/cs with no clock edge.
    @(negedge clk);
    imm = 15'h4000; cs = 1'b1; #1;
    check("comb const sext", constant, 32'hFFFFC000);
    cs = 1'b0; #1;
    check("comb const zext", constant, 32'h00004000);
    imm = 15'h3FFF; cs = 1'b1; #1;
    check("comb const pos", constant, 32'h00003FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
